// File: rtl/alu_shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshakes and a sideband tag.
// Define SHIFT_OVF_EN to add the SLL significance-loss flag (out_ovf).

module alu_shift_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int TAG_W   = 5,
    parameter int BIT     = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               vld_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [1:0]         mode_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               sign_i,
`ifdef SHIFT_OVF_EN
    input  logic               ovf_i,
    output logic               ovf_o,
`endif
    output logic               vld_o,
    output logic [WIDTH-1:0]   data_o,
    output logic [SHAMT_W-1:0] shamt_o,
    output logic [1:0]         mode_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic               sign_o
);
    localparam int AMT = 1 << BIT;
    localparam logic [1:0] M_SLL = 2'b00;
    localparam logic [1:0] M_SRL = 2'b01;
    localparam logic [1:0] M_SRA = 2'b10;

    logic               vld_q;
    logic [WIDTH-1:0]   data_d, data_q;
    logic [SHAMT_W-1:0] shamt_q;
    logic [1:0]         mode_q;
    logic [TAG_W-1:0]   tag_q;
    logic               sign_q;

    always_comb begin
        data_d = data_i;
        if (shamt_i[BIT]) begin
            case (mode_i)
                M_SLL:   data_d = data_i << AMT;
                M_SRL:   data_d = data_i >> AMT;
                // SRA fills from the sign captured at entry, not the current MSB
                M_SRA:   data_d = (data_i >> AMT) | ({WIDTH{sign_i}} << (WIDTH - AMT));
                default: data_d = (data_i >> AMT) | (data_i << (WIDTH - AMT));
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q   <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= '0;
            tag_q   <= '0;
            sign_q  <= 1'b0;
        end else if (flush_i) begin
            vld_q <= 1'b0;
        end else if (load_i) begin
            vld_q <= vld_i;
            if (vld_i) begin
                data_q  <= data_d;
                shamt_q <= shamt_i;
                mode_q  <= mode_i;
                tag_q   <= tag_i;
                sign_q  <= sign_i;
            end
        end
    end

`ifdef SHIFT_OVF_EN
    logic ovf_d, ovf_q;

    // Any bit leaving the top, or the new MSB, disagreeing with the entry sign means loss.
    always_comb begin
        ovf_d = ovf_i;
        if (mode_i == M_SLL && shamt_i[BIT])
            ovf_d = ovf_i | (|(data_i[WIDTH-1 -: AMT] ^ {AMT{sign_i}})) | (data_d[WIDTH-1] ^ sign_i);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            ovf_q <= 1'b0;
        else if (!flush_i && load_i && vld_i)
            ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`endif

    assign vld_o   = vld_q;
    assign data_o  = data_q;
    assign shamt_o = shamt_q;
    assign mode_o  = mode_q;
    assign tag_o   = tag_q;
    assign sign_o  = sign_q;
endmodule

module alu_shift_pipe #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int TAG_W   = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    input  logic [1:0]         ctrl_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out,
    output logic [TAG_W-1:0]   out_tag
`ifdef SHIFT_OVF_EN
   ,output logic               out_ovf
`endif
);
    logic [SHAMT_W-1:0]              vld_pipe;
    logic [SHAMT_W-1:0]              rdy;
    logic [SHAMT_W-1:0][WIDTH-1:0]   data_p;
    logic [SHAMT_W-1:0][SHAMT_W-1:0] shamt_p;
    logic [SHAMT_W-1:0][1:0]         mode_p;
    logic [SHAMT_W-1:0][TAG_W-1:0]   tag_p;
    logic [SHAMT_W-1:0]              sign_p;
`ifdef SHIFT_OVF_EN
    logic [SHAMT_W-1:0]              ovf_p;
`endif
    logic in_fire;

    // A stage can load when empty or when its occupant leaves this cycle.
    always_comb begin
        rdy = '0;
        rdy[SHAMT_W-1] = !vld_pipe[SHAMT_W-1] || out_ready;
        for (int k = SHAMT_W-2; k >= 0; k--)
            rdy[k] = !vld_pipe[k] || rdy[k+1];
    end

    assign in_ready = rdy[0] && !flush;
    assign in_fire  = in_valid && in_ready;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        logic               vld_in;
        logic [WIDTH-1:0]   data_in;
        logic [SHAMT_W-1:0] shamt_in;
        logic [1:0]         mode_in;
        logic [TAG_W-1:0]   tag_in;
        logic               sign_in;
`ifdef SHIFT_OVF_EN
        logic               ovf_in;
`endif
        if (k == 0) begin : g_head
            assign vld_in   = in_fire;
            assign data_in  = A;
            assign shamt_in = ctrl_shiftamt;
            assign mode_in  = ctrl_mode;
            assign tag_in   = in_tag;
            assign sign_in  = A[WIDTH-1];
`ifdef SHIFT_OVF_EN
            assign ovf_in   = 1'b0;
`endif
        end else begin : g_body
            assign vld_in   = vld_pipe[k-1];
            assign data_in  = data_p[k-1];
            assign shamt_in = shamt_p[k-1];
            assign mode_in  = mode_p[k-1];
            assign tag_in   = tag_p[k-1];
            assign sign_in  = sign_p[k-1];
`ifdef SHIFT_OVF_EN
            assign ovf_in   = ovf_p[k-1];
`endif
        end

        alu_shift_stage #(
            .WIDTH  (WIDTH),
            .SHAMT_W(SHAMT_W),
            .TAG_W  (TAG_W),
            .BIT    (SHAMT_W-1-k)
        ) u_stage (
            .clock  (clock),
            .reset  (reset),
            .flush_i(flush),
            .load_i (rdy[k]),
            .vld_i  (vld_in),
            .data_i (data_in),
            .shamt_i(shamt_in),
            .mode_i (mode_in),
            .tag_i  (tag_in),
            .sign_i (sign_in),
`ifdef SHIFT_OVF_EN
            .ovf_i  (ovf_in),
            .ovf_o  (ovf_p[k]),
`endif
            .vld_o  (vld_pipe[k]),
            .data_o (data_p[k]),
            .shamt_o(shamt_p[k]),
            .mode_o (mode_p[k]),
            .tag_o  (tag_p[k]),
            .sign_o (sign_p[k])
        );
    end

    assign out_valid = vld_pipe[SHAMT_W-1];
    assign out       = data_p[SHAMT_W-1];
    assign out_tag   = tag_p[SHAMT_W-1];
`ifdef SHIFT_OVF_EN
    assign out_ovf   = ovf_p[SHAMT_W-1];
`endif

    // Control sideband of the final stage has no consumer.
    logic unused_tail;
    assign unused_tail = ^{shamt_p[SHAMT_W-1], mode_p[SHAMT_W-1], sign_p[SHAMT_W-1]};
endmodule

// File: tb/tb_alu_shift_pipe.sv
// Self-checking bench for alu_shift_pipe: directed vectors, backpressure, flush, reset, random traffic.
module tb_alu_shift_pipe;
    localparam int W = 32;
    localparam int SW = 5;
    localparam int TW = 5;
    localparam int LAT = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  A = '0;
    logic [SW-1:0] sh = '0;
    logic [1:0]    mode = '0;
    logic [TW-1:0] tag = '0;
    logic          in_ready, out_valid, out_ovf;
    logic [W-1:0]  out;
    logic [TW-1:0] out_tag;

    alu_shift_pipe dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .A(A),
        .ctrl_shiftamt(sh), .ctrl_mode(mode), .in_tag(tag),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .out_tag(out_tag)
`ifdef SHIFT_OVF_EN
       ,.out_ovf(out_ovf)
`endif
    );
`ifndef SHIFT_OVF_EN
    assign out_ovf = 1'b0;
`endif

    always #5 clock = ~clock;

    typedef struct { logic [W-1:0] out; logic [TW-1:0] tag; logic ovf; int cyc; } exp_t;
    typedef struct { logic [W-1:0] a; logic [SW-1:0] sh; logic [1:0] mode; logic [W-1:0] eo; logic eovf; } vec_t;

    exp_t          sb[$];
    int            n_chk = 0, n_fail = 0, cyc = 0, n_acc = 0, n_pop = 0;
    bit            lat_chk = 0, prev_stall = 0, prev_flush = 0, s_fire = 0, s_in_ready = 0;
    logic [W-1:0]  prev_out, cur_exp;
    logic [TW-1:0] prev_tag;
    logic          cur_ovf;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] m_shift(input logic [W-1:0] a, input int s, input logic [1:0] m);
        logic [2*W-1:0] dbl;
        case (m)
            2'd0: return a << s;
            2'd1: return a >> s;
            2'd2: return $unsigned($signed(a) >>> s);
            default: begin dbl = {a, a} >> s; return dbl[W-1:0]; end
        endcase
    endfunction

    // Loss of significance: shifting back arithmetically fails to recover A.
    function automatic logic m_ovf(input logic [W-1:0] a, input int s, input logic [1:0] m);
        logic [W-1:0] r;
        if (m != 2'd0) return 1'b0;
        r = a << s;
        return ($signed(r) >>> s) != $signed(a);
    endfunction

    task automatic tick();
        exp_t e;
        #1;
        if (prev_flush) chk("flush_out_valid", out_valid, 0);
        if (prev_stall && !prev_flush) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_out", out, prev_out);
            chk("hold_tag", out_tag, prev_tag);
        end
        if (flush) chk("flush_in_ready", in_ready, 0);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_out: got tag %0h out %0h with nothing expected", out_tag, out);
            end else begin
                e = sb.pop_front();
                n_pop++;
                chk("out", out, e.out);
                chk("out_tag", out_tag, e.tag);
`ifdef SHIFT_OVF_EN
                chk("out_ovf", out_ovf, e.ovf);
`endif
                if (lat_chk) chk("latency", cyc - e.cyc, LAT);
            end
        end
        s_in_ready = in_ready;
        s_fire = in_valid && in_ready;
        if (flush) sb.delete();
        else if (s_fire) begin
            sb.push_back('{cur_exp, tag, cur_ovf, cyc});
            n_acc++;
        end
        prev_stall = out_valid && !out_ready;
        prev_out = out;
        prev_tag = out_tag;
        prev_flush = flush;
        @(negedge clock);
        cyc++;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [SW-1:0] s, input logic [1:0] m,
                         input logic [TW-1:0] t, input logic [W-1:0] eo, input logic eovf);
        A = a; sh = s; mode = m; tag = t; cur_exp = eo; cur_ovf = eovf;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (s_fire) break;
        end
        if (!s_fire) begin
            n_chk++; n_fail++;
            $display("FAIL issue_timeout: got no accept expected accept for tag %0h", t);
        end
        in_valid = 1'b0;
    endtask

    task automatic issue_m(input logic [W-1:0] a, input logic [SW-1:0] s, input logic [1:0] m, input logic [TW-1:0] t);
        issue(a, s, m, t, m_shift(a, int'(s), m), m_ovf(a, int'(s), m));
    endtask

    task automatic drain();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
        chk("drain_empty", sb.size(), 0);
        repeat (LAT + 1) tick();
    endtask

    vec_t vecs[15];
    int   acc0, pop0;

    initial begin
        vecs[0]  = '{32'h8000_0000, 5'd4,  2'd2, 32'hF800_0000, 1'b0};
        vecs[1]  = '{32'h8000_0000, 5'd4,  2'd1, 32'h0800_0000, 1'b0};
        vecs[2]  = '{32'h0000_0001, 5'd1,  2'd3, 32'h8000_0000, 1'b0};
        vecs[3]  = '{32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000, 1'b1};
        vecs[4]  = '{32'h4000_0000, 5'd1,  2'd0, 32'h8000_0000, 1'b1};
        vecs[5]  = '{32'hFFFF_FFFF, 5'd4,  2'd0, 32'hFFFF_FFF0, 1'b0};
        vecs[6]  = '{32'hA5C3_5A3C, 5'd0,  2'd0, 32'hA5C3_5A3C, 1'b0};
        vecs[7]  = '{32'hA5C3_5A3C, 5'd0,  2'd1, 32'hA5C3_5A3C, 1'b0};
        vecs[8]  = '{32'hA5C3_5A3C, 5'd0,  2'd2, 32'hA5C3_5A3C, 1'b0};
        vecs[9]  = '{32'hA5C3_5A3C, 5'd0,  2'd3, 32'hA5C3_5A3C, 1'b0};
        vecs[10] = '{32'h8000_1234, 5'd31, 2'd2, 32'hFFFF_FFFF, 1'b0};
        vecs[11] = '{32'h7FFF_FFFF, 5'd31, 2'd2, 32'h0000_0000, 1'b0};
        vecs[12] = '{32'h1234_5678, 5'd8,  2'd3, 32'h7812_3456, 1'b0};
        vecs[13] = '{32'h0000_00FF, 5'd8,  2'd0, 32'h0000_FF00, 1'b0};
        vecs[14] = '{32'hF000_0000, 5'd31, 2'd1, 32'h0000_0001, 1'b0};

        // reset state
        repeat (2) @(negedge clock);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out", out, 0);
        chk("reset_out_tag", out_tag, 0);
        chk("reset_out_ovf", out_ovf, 0);
        @(negedge clock);
        reset = 1'b1;
        #1 chk("post_reset_in_ready", in_ready, 1);
        @(negedge clock);

        // directed vectors, back-to-back, no stalls
        lat_chk = 1; out_ready = 1'b1;
        for (int i = 0; i < 15; i++)
            issue(vecs[i].a, vecs[i].sh, vecs[i].mode, TW'(i + 3), vecs[i].eo, vecs[i].eovf);
        drain();

        // backpressure: 7 ops against a stalled output
        lat_chk = 0; out_ready = 1'b0; acc0 = n_acc; pop0 = n_pop;
        for (int t = 0; t < 5; t++) issue_m(32'h9000_0000 + W'(t), SW'(t), 2'(t), TW'(t));
        A = 32'h9000_0005; sh = 5'd5; mode = 2'd1; tag = 5'd5;
        cur_exp = m_shift(A, 5, 2'd1); cur_ovf = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_in_ready", s_in_ready, 0);
        end
        chk("bp_accepted", n_acc - acc0, 5);
        out_ready = 1'b1;
        issue_m(32'h9000_0005, 5'd5, 2'd1, 5'd5);
        issue_m(32'h9000_0006, 5'd6, 2'd2, 5'd6);
        drain();
        chk("bp_delivered", n_pop - pop0, 7);

        // flush with 3 ops in flight, then a new op right after
        lat_chk = 1; out_ready = 1'b1;
        for (int t = 0; t < 3; t++) issue_m(32'h0F0F_0F0F, 5'd3, 2'd3, TW'(10 + t));
        A = 32'hDEAD_BEEF; sh = 5'd1; mode = 2'd0; tag = 5'd20; in_valid = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        issue_m(32'h8765_4321, 5'd7, 2'd2, 5'd21);
        drain();

        // reset while streaming
        for (int t = 0; t < 6; t++) issue_m(32'h1357_9BDF, SW'(t), 2'd1, TW'(24 + t));
        chk("pre_reset_out_valid", out_valid, 1);
        reset = 1'b0;
        #1;
        chk("async_reset_out_valid", out_valid, 0);
        chk("async_reset_out", out, 0);
        chk("async_reset_out_tag", out_tag, 0);
        sb.delete(); prev_stall = 0; prev_flush = 0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1 chk("rst_release_in_ready", in_ready, 1);
        @(negedge clock);
        issue_m(32'hC000_0001, 5'd2, 2'd0, 5'd31);
        drain();

        // random traffic with stalls and occasional flush
        lat_chk = 0;
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            A = $urandom; sh = SW'($urandom); mode = 2'($urandom); tag = TW'($urandom);
            cur_exp = m_shift(A, int'(sh), mode); cur_ovf = m_ovf(A, int'(sh), mode);
            out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 49) == 0);
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/alu_shift_pipe.md
Name: alu_shift_pipe

Overview:
Parametrised, pipelined barrel shifter for the processor ALU path.
- Supports logical left (SLL), logical right (SRL), arithmetic right (SRA) and rotate right (ROR).
- One register stage per shift-amount bit, MSB stage first.
- Valid/ready handshakes at input and output, with full backpressure.
- A tag field travels alongside each operand so writeback can match results to destination registers.

Parameters:
- WIDTH, 32, operand width in bits; power of two, minimum 4.
- SHAMT_W, $clog2(WIDTH), shift-amount width; also the number of pipeline stages.
- TAG_W, 5, width of the sideband tag carried with each operand.

Ports:
- clock  input  1  single clock for the block; rising-edge triggered.
- reset  input  1  asynchronous, active-low reset; clears all state.
- flush  input  1  synchronous; drops every in-flight operation.
- in_valid  input  1  an operand is presented this cycle.
- in_ready  output  1  block accepts the operand this cycle.
- A  input  WIDTH  operand.
- ctrl_shiftamt  input  SHAMT_W  shift distance.
- ctrl_mode  input  2  operation select: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  a result is available.
- out_ready  input  1  downstream consumes the result.
- out  output  WIDTH  shift result.
- out_tag  output  TAG_W  tag of the result.
- out_ovf  output  1  SLL significance-loss flag; present only when SHIFT_OVF_EN is defined.

Behaviour:
- Reset (reset=0, asynchronous): all stage valid bits=0. out_valid=0, out=0, out_tag=0, out_ovf=0. in_ready=1 once reset is released.
- Pipeline structure: SHAMT_W stages, indexed k=0..SHAMT_W-1.
  - Stage k applies a shift of 2^(SHAMT_W-1-k) when shift-amount bit (SHAMT_W-1-k) is 1; otherwise it passes data through.
  - Each stage registers: data, remaining shift-amount bits, mode, tag, valid, and (with the optional feature) ovf.
- Fill bits per mode:
  - SLL: zeros enter at the LSB end.
  - SRL: zeros enter at the MSB end.
  - SRA: copies of the original A[WIDTH-1] enter at the MSB end; the sign is captured in stage 0 and carried down the pipe.
  - ROR: bits leaving the LSB end re-enter at the MSB end.
- Shift of 0: result equals A in every mode.
- Maximum shift (WIDTH-1) in SRA: out is all copies of the sign bit.
- Latency: exactly SHAMT_W cycles from the input handshake (in_valid&in_ready) to out_valid, when out_ready is held high. Example: 5 cycles at WIDTH=32.
- Throughput: one operation per cycle when there are no stalls.
- Stage advance rule: stage k loads from stage k-1 when stage k is empty, or when stage k's contents move forward the same cycle. The last stage moves forward on out_valid&out_ready.
- in_ready = !stage0_valid || stage0_advancing. This is combinational from out_ready through the chain. No bubble is inserted when the pipe is full and draining.
- Simultaneous in_valid and out_ready with a full pipe: the oldest operation leaves and the new one enters in the same cycle; occupancy is unchanged.
- out, out_tag and out_ovf are held stable while out_valid=1 and out_ready=0.
- Operands are never dropped or duplicated under any stall pattern.
- flush=1:
  - All valid bits clear at the next edge.
  - in_ready=0 during the flush cycle; any in_valid in that cycle is ignored.
  - Data registers may keep stale values; out_valid=0 masks them.
- reset asserted mid-operation: all in-flight results are lost and out_valid drops immediately (asynchronous).

Optional Feature:
- Macro: SHIFT_OVF_EN.
- Defined:
  - out_ovf is present and valid together with out_valid.
  - In SLL mode, out_ovf=1 if any bit shifted out, or the resulting MSB, differs from the original A[WIDTH-1]; that is, the signed value changed.
  - Each stage ORs in its own contribution.
  - out_ovf=0 for SRL, SRA and ROR.
- Undefined: the out_ovf port and its pipeline bits do not exist. All other behaviour and the latency are identical.

Test Plan:
- WIDTH=32, SRA, A=0x80000000, shamt=4, tag=3 -> 5 cycles later out=0xF8000000, out_tag=3; SRL with the same operand gives out=0x08000000.
- ROR, A=0x00000001, shamt=1 -> out=0x80000000. SLL, A=0x00000001, shamt=31 -> out=0x80000000; out_ovf=1 with SHIFT_OVF_EN.
- SLL, A=0x40000000, shamt=1 -> out=0x80000000, out_ovf=1. SLL, A=0xFFFFFFFF, shamt=4 -> out=0xFFFFFFF0, out_ovf=0.
- Backpressure: issue 7 back-to-back ops (tags 0..6) with out_ready=0.
  - in_ready drops after 5 ops are accepted.
  - Raising out_ready yields tags 0..6 in order with no loss or duplication.
  - out is stable while stalled.
- Flush with 3 ops in flight -> out_valid=0 the next cycle. A new op issued 1 cycle after the flush emerges 5 cycles later with the correct value.
- Assert reset during streaming -> out_valid=0 immediately and in_ready=1 after release. Shift of 0 in all four modes returns A unchanged.
